fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the IF/ID pipeline input: the instruction word, its PC and a valid flag, consumed by the decode stage.
- Issues in-order requests to instruction memory and buffers returned words in a small prefetch queue.
- Absorbs decode back-pressure through a valid/ready handshake.
- Handles control-flow redirects (taken branch, jump) by flushing the queue and discarding stale in-flight responses.

Parameters:
- XLEN, 32, data and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, prefetch-queue entries; also the maximum of (outstanding requests + queued entries). Must be a power of 2, ≥2.

Ports:
- clk  in  1  clock; all state on posedge
- rst_n  in  1  synchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; responses return in order
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  redirect from EX/WB (branch taken / jump)
- redirect_pc  in  XLEN  redirect target
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts instruction
- id_inst  out  32  instruction word
- id_pc  out  XLEN  PC of id_inst

Behaviour:
- Reset (rst_n=0 at posedge):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - outstanding=0, drop_cnt=0, queue empty.
  - While rst_n=0: imem_req_valid=0, id_valid=0, id_inst=32'h00000013 (NOP), id_pc=0.
- Request:
  - imem_req_valid = !redirect_valid && (outstanding + count < DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding++.
- Response:
  - Memory latency ≥1 cycle, any length, at most one response per cycle.
  - On imem_rsp_valid: outstanding--.
  - If drop_cnt>0: data discarded and drop_cnt--.
  - Otherwise push {imem_rsp_data, rsp_pc} and rsp_pc += 4.
  - The credit rule guarantees no push into a full queue. A response with outstanding==0 is illegal; assert in simulation.
- Decode side:
  - id_valid = queue non-empty && !redirect_valid.
  - id_inst/id_pc come from the queue head.
  - Pop on id_valid && id_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect (redirect_valid=1 at posedge), overrides everything else:
  - Queue flushed.
  - fetch_pc and rsp_pc set to {redirect_pc[XLEN-1:2],2'b00}; low bits are silently cleared.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0). Any response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - First post-redirect request goes out the following cycle.
- Back-to-back redirects: each one restarts; drop_cnt is recomputed from the current outstanding.
- Steady state with 1-cycle memory and id_ready=1: one instruction per cycle; first id_valid 2 cycles after reset release.
- Reset mid-operation: all state cleared; responses for pre-reset requests are the memory's responsibility to squash (the memory is reset with the same rst_n).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cycles[31:0] and perf_redirects[31:0]:
  - perf_stall_cycles increments each cycle id_valid=1 && id_ready=0.
  - perf_redirects increments per redirect cycle.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package cpu_pkg: XLEN, NOP_INST=32'h00000013, opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL), and typedef fetch_entry_t {inst[31:0], pc[XLEN-1:0]}.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t, with push, pop, flush, count, empty and full.
- fetch_unit holds the PC, outstanding/drop counters and handshake logic.

Test Plan:
- Release reset, memory latency 1, always ready, id_ready=1, RESET_PC=0 -> id_pc 0x0,0x4,0x8,… one per cycle from cycle 2; id_inst matches memory image.
- Hold id_ready=0 for 10 cycles -> exactly 4 requests issued (addresses 0x0–0xC) and then imem_req_valid=0; release -> ids 0x0,0x4,0x8,0xC,0x10 with no gap or loss.
- Latency 3, redirect to 0x100 with 2 outstanding -> two responses dropped; next id_pc=0x100 with inst from 0x100; no stale PC ever appears on id_pc.
- redirect_pc=0x103 -> imem_req_addr=0x100 next cycle; redirect coincident with a response -> that response dropped and drop_cnt=outstanding−1.
- imem_req_ready toggling randomly, 20 redirects to random targets -> id_pc stream always equals the architecturally expected sequence (scoreboard).
- rst_n low for 1 cycle mid-stream with queue full -> next cycle id_valid=0 and outstanding=0; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN: 5 stall cycles and 2 redirects -> counters read 5 and 2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding, base opcodes and the
// fetch queue entry type used between fetch_unit and fetch_fifo.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Instruction addresses are word aligned; stray low bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input
// and the IF/ID handshake. The master modport is the fetch unit itself.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; flush wins over
// push/pop. Storage is not reset, only the pointers and count.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch into a prefetch queue,
// redirect flush with stale-response dropping. Optional FETCH_PERF_CNT_EN adds
// stall/redirect performance counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_redirects
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_use;
    logic             fifo_empty, fifo_full;
    logic             req_fire, rsp_keep, id_fire;
    fetch_entry_t     push_entry, head_entry;

    // Outstanding requests plus queued words never exceed DEPTH, so every
    // response always has a free queue slot waiting for it.
    assign in_use   = {1'b0, outstanding_q} + {1'b0, fifo_count};

    assign bus.imem_req_valid = rst_n && !bus.redirect_valid
                                && (in_use < (CNT_W+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.id_valid       = rst_n && !fifo_empty && !bus.redirect_valid;
    assign bus.id_inst        = rst_n ? head_entry.inst : NOP_INST;
    assign bus.id_pc          = rst_n ? head_entry.pc   : '0;

    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign id_fire    = bus.id_valid && bus.id_ready;
    assign rsp_keep   = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q == '0);
    assign push_entry = '{inst: bus.imem_rsp_data, pc: rsp_pc_q};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (id_fire),
        .flush     (bus.redirect_valid),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (bus.redirect_valid) begin
            // Everything still in flight belongs to the old path.
            fetch_pc_d    = align_pc(bus.redirect_pc);
            rsp_pc_d      = align_pc(bus.redirect_pc);
            outstanding_d = outstanding_q - CNT_W'(bus.imem_rsp_valid);
            drop_cnt_d    = outstanding_q - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (outstanding_q != '0));

    a_push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_keep |-> !fifo_full);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (bus.id_valid && !bus.id_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bus.redirect_valid && (redir_cnt_q != '1)) begin
            redir_cnt_d = redir_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_redirects    = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behavioural memory with configurable latency, an
// architectural PC-stream scoreboard, directed corner cases and random redirects.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    mem_req_t    pending[$];
    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          cycle      = 0;
    int          mem_lat    = 1;
    int          ready_pct  = 100;
    int          fire_count = 0;
    logic [31:0] last_fire_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Architectural view: decode must see consecutive words from the last
    // reset/redirect target, word aligned, wrapping at 2^32.
    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = {pc[31:2], 2'b00};
    endtask

    task automatic model_top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic apply_stimulus(input logic redir, input logic [31:0] target,
                                  input logic rdy);
        @(posedge clk);
        #1;
        bus.redirect_valid = redir;
        bus.redirect_pc    = target;
        bus.id_ready       = rdy;
        if (redir) model_restart(target);
        model_top_up();
    endtask

    task automatic sample();
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.id_ready       = rdy;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        fire_count = 0;
        model_restart(RESET_PC);
        model_top_up();
    endtask

    // In-order memory: a request accepted at an edge returns mem_lat edges later.
    initial begin : mem_model
        logic        fire;
        logic        taken;
        logic [31:0] a;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_req_ready = 1'b1;
        forever begin
            @(negedge clk);
            #3;
            fire  = (rst_n === 1'b1) && bus.imem_req_valid && bus.imem_req_ready;
            a     = bus.imem_req_addr;
            taken = bus.imem_rsp_valid;
            @(posedge clk);
            cycle++;
            if (rst_n !== 1'b1) begin
                pending.delete();
            end else begin
                if (taken) void'(pending.pop_front());
                if (fire) begin
                    pending.push_back('{a, cycle + mem_lat - 1});
                    fire_count++;
                    last_fire_addr = a;
                end
            end
            #1;
            bus.imem_req_ready = ($urandom_range(99) < ready_pct);
            if (pending.size() > 0 && pending[0].due <= cycle) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pending[0].addr);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_underflow: got pc %h expected none", bus.id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("id_pc", bus.id_pc, e.pc);
                    check_output("id_inst", bus.id_inst, e.inst);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int          gaps;
        int          found;
        int          got;
        int          exp_drop;
        logic [31:0] target;

        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;
        model_restart(RESET_PC);
        repeat (3) @(posedge clk);
        #1;

        // Reset values while rst_n is low.
        sample();
        check_output("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_output("rst_id_valid",  32'(bus.id_valid), 32'd0);
        check_output("rst_id_inst",   bus.id_inst, NOP_INST);
        check_output("rst_id_pc",     bus.id_pc, 32'd0);

        // Release: request in cycle 0, first id_valid in cycle 2.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_restart(RESET_PC);
        model_top_up();
        sample();
        check_output("c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_output("c0_req_addr",  bus.imem_req_addr, RESET_PC);
        check_output("c0_id_valid",  32'(bus.id_valid), 32'd0);
        apply_stimulus(1'b0, '0, 1'b1);
        sample();
        check_output("c1_id_valid", 32'(bus.id_valid), 32'd0);
        apply_stimulus(1'b0, '0, 1'b1);
        sample();
        check_output("c2_id_valid", 32'(bus.id_valid), 32'd1);
        check_output("c2_id_pc",    bus.id_pc, RESET_PC);
        gaps = 0;
        repeat (20) begin
            apply_stimulus(1'b0, '0, 1'b1);
            sample();
            if (!bus.id_valid) gaps++;
        end
        check_output("steady_gaps", 32'(gaps), 32'd0);

        // Decode back-pressure from reset: credit stops fetch after DEPTH requests.
        do_reset(1'b0);
        repeat (9) apply_stimulus(1'b0, '0, 1'b0);
        sample();
        check_output("bp_fire_count", 32'(fire_count), 32'd4);
        check_output("bp_last_addr",  last_fire_addr, 32'h0000_000C);
        check_output("bp_req_valid",  32'(bus.imem_req_valid), 32'd0);
        check_output("bp_id_pc",      bus.id_pc, 32'h0);
        gaps = 0;
        repeat (8) begin
            apply_stimulus(1'b0, '0, 1'b1);
            sample();
            if (!bus.id_valid) gaps++;
        end
        check_output("bp_release_gaps", 32'(gaps), 32'd0);

        // Latency 3: redirect with two requests outstanding.
        mem_lat = 3;
        do_reset(1'b1);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, '0, 1'b1);
            @(negedge clk);
            #1;
            if (pending.size() == 2) begin
                found = 1;
                break;
            end
        end
        check_output("two_outstanding_found", 32'(found), 32'd1);
        exp_drop = 2 - int'(bus.imem_rsp_valid);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        model_restart(32'h0000_0100);
        model_top_up();
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("redir_drop_cnt", 32'(dut.drop_cnt_q), 32'(exp_drop));
        got = 0;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (bus.id_valid && got == 0) begin
                got = 1;
                check_output("redir_first_pc",   bus.id_pc, 32'h0000_0100);
                check_output("redir_first_inst", bus.id_inst, mem_word(32'h0000_0100));
            end
            apply_stimulus(1'b0, '0, 1'b1);
        end
        check_output("redir_first_seen", 32'(got), 32'd1);

        // Redirect coincident with a response, unaligned target.
        found = 0;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(1'b0, '0, 1'b1);
            @(negedge clk);
            #1;
            if (bus.imem_rsp_valid && pending.size() >= 2) begin
                found = 1;
                break;
            end
        end
        check_output("coincident_found", 32'(found), 32'd1);
        exp_drop = pending.size() - 1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        model_restart(32'h0000_0103);
        model_top_up();
        sample();
        check_output("redir_cycle_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_output("redir_cycle_id_valid",  32'(bus.id_valid), 32'd0);
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("coinc_drop_cnt",    32'(dut.drop_cnt_q), 32'(exp_drop));
        check_output("coinc_outstanding", 32'(dut.outstanding_q), 32'(exp_drop));
        sample();
        check_output("unaligned_req_addr", bus.imem_req_addr, 32'h0000_0100);
        repeat (20) apply_stimulus(1'b0, '0, 1'b1);

        // Random memory readiness, latency and decode readiness with redirects.
        ready_pct = 70;
        for (int r = 0; r < 20; r++) begin
            mem_lat = $urandom_range(1, 4);
            repeat ($urandom_range(3, 25)) apply_stimulus(1'b0, '0, $urandom_range(99) < 75);
            target = (r % 5 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            apply_stimulus(1'b1, target, $urandom_range(99) < 75);
            if (r % 4 == 1) apply_stimulus(1'b1, $urandom, 1'b1);
        end
        ready_pct = 100;
        repeat (30) apply_stimulus(1'b0, '0, 1'b1);

        // Reset mid-stream with a full queue.
        mem_lat = 1;
        repeat (10) apply_stimulus(1'b0, '0, 1'b0);
        sample();
        check_output("full_id_valid", 32'(bus.id_valid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sample();
        check_output("midrst_low_id_valid", 32'(bus.id_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        model_restart(RESET_PC);
        model_top_up();
        sample();
        check_output("midrst_id_valid",    32'(bus.id_valid), 32'd0);
        check_output("midrst_outstanding", 32'(dut.outstanding_q), 32'd0);
        check_output("midrst_req_addr",    bus.imem_req_addr, RESET_PC);
        check_output("midrst_req_valid",   32'(bus.imem_req_valid), 32'd1);
        repeat (15) apply_stimulus(1'b0, '0, 1'b1);

`ifdef FETCH_PERF_CNT_EN
        do_reset(1'b1);
        repeat (5) apply_stimulus(1'b0, '0, 1'b1);
        repeat (5) apply_stimulus(1'b0, '0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0040, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1);
        apply_stimulus(1'b1, 32'h0000_0080, 1'b1);
        repeat (3) apply_stimulus(1'b0, '0, 1'b1);
        sample();
        check_output("perf_stall_cycles", perf_stall_cycles, 32'd5);
        check_output("perf_redirects",    perf_redirects, 32'd2);
`endif

        repeat (5) apply_stimulus(1'b0, '0, 1'b1);
        sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
